// File: rtl/sdrc_bram_responder_if.sv
// Command and data bundle between an SDRAM-controller initiator and its responder.
// The initiator drives the I_ side; the responder answers on the O_/o_ side.
interface sdrc_bram_responder_if;
  logic        I_sdrc_cmd_en;
  logic [2:0]  I_sdrc_cmd;
  logic        I_sdrc_precharge_ctrl;
  logic        I_sdram_power_down;
  logic        I_sdram_selfrefresh;
  logic [20:0] I_sdrc_addr;
  logic [3:0]  I_sdrc_dqm;
  logic [31:0] I_sdrc_data;
  logic [7:0]  I_sdrc_data_len;
  logic [31:0] O_sdrc_data;
  logic        O_sdrc_init_done;
  logic        O_sdrc_cmd_ack;
  logic        o_proto_err;
  logic        o_refresh_late;

  modport master (
    output I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down,
           I_sdram_selfrefresh, I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
    input  O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack, o_proto_err, o_refresh_late
  );

  modport slave (
    input  I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down,
           I_sdram_selfrefresh, I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
    output O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack, o_proto_err, o_refresh_late
  );
endinterface

// File: rtl/sdrc_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller user port; read beat 0 lands READ_LAT cycles after the command.
// No backpressure: commands outside IDLE are dropped and raise the sticky o_proto_err flag.
module sdrc_bram_responder #(
  parameter int ADDR_W      = 14,
  parameter int INIT_CYCLES = 200,
  parameter int TRCD        = 3,
  parameter int TRP         = 3,
  parameter int TRFC        = 8,
  parameter int READ_LAT    = 4,
  parameter int REFRESH_MAX = 900
) (
  input logic                  sdram_clk,
  input logic                  reset_n,
  sdrc_bram_responder_if.slave bus
);
  localparam int CW = 16;
  localparam int RW = $clog2(REFRESH_MAX + 1);
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_ACT_WAIT, ST_PRE_WAIT, ST_REF_WAIT,
    ST_WR_BURST, ST_RD_WAIT, ST_RD_BURST, ST_LOWPWR
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              row_open_q, row_open_d;
  logic [12:0]       bank_row_q;
  logic [7:0]        col_q, col_d, mem_col, len_q;
  logic              prech_q;
  logic              latch_row, latch_rw, init_set, err_set, ref_clr, ack, wr_en, rd_en;
  logic              init_done_q, proto_err_q, refresh_late_q;
  logic [RW-1:0]     ref_cnt_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [20:0]       word_addr;
  logic [ADDR_W-1:0] mem_idx;
  logic              unused_addr_bits;

  assign word_addr        = {bank_row_q, mem_col};
  assign mem_idx          = word_addr[ADDR_W-1:0];
  assign unused_addr_bits = ^word_addr;

  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      row_open_q  <= 1'b0;
      bank_row_q  <= '0;
      col_q       <= '0;
      len_q       <= '0;
      prech_q     <= 1'b0;
      init_done_q <= 1'b0;
      proto_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_open_q <= row_open_d;
      col_q      <= col_d;
      if (latch_row) bank_row_q <= bus.I_sdrc_addr[20:8];
      if (latch_rw) begin
        len_q   <= bus.I_sdrc_data_len;
        prech_q <= bus.I_sdrc_precharge_ctrl;
      end
      if (init_set) init_done_q <= 1'b1;
      if (err_set)  proto_err_q <= 1'b1;
      if (rd_en)    rdata_q     <= mem[mem_idx];
    end
  end

  // Storage is never reset; a burst cut short by reset keeps the beats already written.
  always_ff @(posedge sdram_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (!bus.I_sdrc_dqm[b]) mem[mem_idx][8*b +: 8] <= bus.I_sdrc_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt_q      <= '0;
      refresh_late_q <= 1'b0;
    end else begin
      if (ref_clr)
        ref_cnt_q <= '0;
      else if (init_done_q && ref_cnt_q != RW'(REFRESH_MAX))
        ref_cnt_q <= ref_cnt_q + RW'(1);
      if (ref_cnt_q == RW'(REFRESH_MAX)) refresh_late_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    row_open_d = row_open_q;
    col_d      = col_q;
    mem_col    = col_q;
    latch_row  = 1'b0;
    latch_rw   = 1'b0;
    init_set   = 1'b0;
    err_set    = 1'b0;
    ref_clr    = 1'b0;
    ack        = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      ST_INIT: begin
        err_set = bus.I_sdrc_cmd_en;
        if (cnt_q == CW'(INIT_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          init_set = 1'b1;
        end
      end
      ST_IDLE: begin
        cnt_d = CW'(1);
        if (bus.I_sdrc_cmd_en) begin
          case (bus.I_sdrc_cmd)
            CMD_ACT: begin
              state_d    = ST_ACT_WAIT;
              latch_row  = 1'b1;
              row_open_d = 1'b1;
            end
            CMD_PRE: begin
              state_d    = ST_PRE_WAIT;
              row_open_d = 1'b0;
            end
            CMD_REF: begin
              state_d = ST_REF_WAIT;
              ref_clr = 1'b1;
              err_set = row_open_q;
            end
            // Beat 0 of a write is taken in the command cycle itself.
            CMD_WR: begin
              if (!row_open_q) err_set = 1'b1;
              else begin
                state_d  = ST_WR_BURST;
                latch_rw = 1'b1;
                wr_en    = 1'b1;
                mem_col  = bus.I_sdrc_addr[7:0];
                col_d    = bus.I_sdrc_addr[7:0] + 8'd1;
              end
            end
            CMD_RD: begin
              if (!row_open_q) err_set = 1'b1;
              else begin
                state_d  = ST_RD_WAIT;
                latch_rw = 1'b1;
                col_d    = bus.I_sdrc_addr[7:0];
              end
            end
            default: ;
          endcase
        end else if (bus.I_sdram_power_down || bus.I_sdram_selfrefresh) begin
          state_d = ST_LOWPWR;
        end
      end
      ST_ACT_WAIT, ST_PRE_WAIT, ST_REF_WAIT: begin
        err_set = bus.I_sdrc_cmd_en;
        if ((state_q == ST_ACT_WAIT && cnt_q == CW'(TRCD)) ||
            (state_q == ST_PRE_WAIT && cnt_q == CW'(TRP))  ||
            (state_q == ST_REF_WAIT && cnt_q == CW'(TRFC))) begin
          ack     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        err_set = bus.I_sdrc_cmd_en;
        if (cnt_q > CW'(len_q)) begin
          ack     = 1'b1;
          state_d = ST_IDLE;
          if (prech_q) row_open_d = 1'b0;
        end else begin
          wr_en = 1'b1;
          col_d = col_q + 8'd1;
        end
      end
      // The address goes to the RAM one cycle before its beat is due on the output.
      ST_RD_WAIT: begin
        err_set = bus.I_sdrc_cmd_en;
        if (cnt_q == CW'(READ_LAT - 1)) begin
          rd_en   = 1'b1;
          col_d   = col_q + 8'd1;
          state_d = ST_RD_BURST;
          cnt_d   = '0;
        end
      end
      ST_RD_BURST: begin
        err_set = bus.I_sdrc_cmd_en;
        if (cnt_q == CW'(len_q)) begin
          ack     = 1'b1;
          state_d = ST_IDLE;
          if (prech_q) row_open_d = 1'b0;
        end else begin
          rd_en = 1'b1;
          col_d = col_q + 8'd1;
        end
      end
      ST_LOWPWR: begin
        err_set = bus.I_sdrc_cmd_en;
        ref_clr = bus.I_sdram_selfrefresh;
        if (!bus.I_sdram_power_down && !bus.I_sdram_selfrefresh) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.O_sdrc_data      = rdata_q;
  assign bus.O_sdrc_init_done = init_done_q;
  assign bus.O_sdrc_cmd_ack   = ack;
  assign bus.o_proto_err      = proto_err_q;
  assign bus.o_refresh_late   = refresh_late_q;
endmodule

// File: tb/tb_sdrc_bram_responder.sv
// Directed bench for sdrc_bram_responder: init, activate/write/read bursts, byte masks, refresh and error flags.
module tb_sdrc_bram_responder;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [20:0] ROW_A  = {2'b01, 11'd5, 8'h00};

  logic sdram_clk = 1'b0;
  logic reset_n   = 1'b0;
  int   n_chk     = 0;
  int   n_pass    = 0;
  logic [31:0] wbeat [4];
  logic [3:0]  wmask [4];
  logic [31:0] rbeat [4];

  sdrc_bram_responder_if bus();

  sdrc_bram_responder dut (
    .sdram_clk (sdram_clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 sdram_clk = ~sdram_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sdram_clk);
      @(negedge sdram_clk);
    end
  endtask

  task automatic idle_inputs();
    bus.I_sdrc_cmd_en         = 1'b0;
    bus.I_sdrc_cmd            = 3'b000;
    bus.I_sdrc_precharge_ctrl = 1'b0;
    bus.I_sdram_power_down    = 1'b0;
    bus.I_sdram_selfrefresh   = 1'b0;
    bus.I_sdrc_addr           = '0;
    bus.I_sdrc_dqm            = 4'h0;
    bus.I_sdrc_data           = '0;
    bus.I_sdrc_data_len       = '0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_init_done"}, 32'(bus.O_sdrc_init_done), 32'd0);
    check({tag, "_ack"},       32'(bus.O_sdrc_cmd_ack),   32'd0);
    check({tag, "_proto_err"}, 32'(bus.o_proto_err),      32'd0);
    check({tag, "_late"},      32'(bus.o_refresh_late),   32'd0);
    check({tag, "_data"},      bus.O_sdrc_data,           32'd0);
  endtask

  task automatic do_reset();
    int i;
    reset_n = 1'b0;
    idle_inputs();
    step(2);
    reset_n = 1'b1;
    i = 0;
    while (i < 300 && !bus.O_sdrc_init_done) begin
      step(1);
      i++;
    end
    check("reinit_done", 32'(bus.O_sdrc_init_done), 32'd1);
  endtask

  // Drives a one-cycle command; returns in cycle C+1.
  task automatic send(input logic [2:0] c, input logic [20:0] a, input logic [7:0] len, input logic pc);
    bus.I_sdrc_cmd            = c;
    bus.I_sdrc_addr           = a;
    bus.I_sdrc_data_len       = len;
    bus.I_sdrc_precharge_ctrl = pc;
    bus.I_sdrc_cmd_en         = 1'b1;
    step(1);
    bus.I_sdrc_cmd_en         = 1'b0;
  endtask

  task automatic wait_ack(input int maxc, output int k);
    k = -1;
    for (int c = 1; c <= maxc; c++) begin
      if (bus.O_sdrc_cmd_ack) begin
        k = c;
        break;
      end
      step(1);
    end
  endtask

  task automatic wr_burst(input string tag, input logic [20:0] a, input int len, input logic pc);
    bus.I_sdrc_data = wbeat[0];
    bus.I_sdrc_dqm  = wmask[0];
    send(CMD_WR, a, 8'(len), pc);
    for (int k = 1; k <= len; k++) begin
      bus.I_sdrc_data = wbeat[k];
      bus.I_sdrc_dqm  = wmask[k];
      step(1);
    end
    check({tag, "_ack"}, 32'(bus.O_sdrc_cmd_ack), 32'd1);
    step(1);
    check({tag, "_ack_end"}, 32'(bus.O_sdrc_cmd_ack), 32'd0);
  endtask

  // Checks every beat and the ack position; optionally injects a command during beat inj.
  task automatic rd_burst(input string tag, input logic [20:0] a, input int len, input logic pc, input int inj);
    send(CMD_RD, a, 8'(len), pc);
    step(3);
    for (int k = 0; k <= len; k++) begin
      bus.I_sdrc_cmd_en = (k == inj);
      bus.I_sdrc_cmd    = CMD_RD;
      check($sformatf("%s_beat%0d", tag, k), bus.O_sdrc_data, rbeat[k]);
      check($sformatf("%s_ack%0d", tag, k), 32'(bus.O_sdrc_cmd_ack), 32'(k == len));
      step(1);
    end
    bus.I_sdrc_cmd_en = 1'b0;
  endtask

  initial begin
    int k;
    logic saw_ack;
    idle_inputs();
    reset_n = 1'b0;
    @(negedge sdram_clk);
    step(2);
    check_zero_outputs("rst");

    // Init window with a stray command in cycle 50.
    reset_n = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      step(1);
      if (c == 50) begin
        bus.I_sdrc_cmd    = CMD_ACT;
        bus.I_sdrc_cmd_en = 1'b1;
      end
      if (c == 51) bus.I_sdrc_cmd_en = 1'b0;
      if (c == 199) check("init_done_199", 32'(bus.O_sdrc_init_done), 32'd0);
      if (c == 200) check("init_done_200", 32'(bus.O_sdrc_init_done), 32'd1);
    end
    check("init_cmd_err", 32'(bus.o_proto_err), 32'd1);

    // Refresh with row closed, then let the interval expire.
    do_reset();
    send(CMD_REF, '0, 8'd0, 1'b0);
    wait_ack(20, k);
    check("ref_ack_cycle", 32'(k), 32'd8);
    check("ref_no_err", 32'(bus.o_proto_err), 32'd0);
    step(840);
    check("late_before", 32'(bus.o_refresh_late), 32'd0);
    step(60);
    check("late_after", 32'(bus.o_refresh_late), 32'd1);

    // Activate, column-wrapping write burst, immediate read-back.
    do_reset();
    send(CMD_ACT, ROW_A, 8'd0, 1'b0);
    wait_ack(20, k);
    check("act_ack_cycle", 32'(k), 32'd3);
    step(1);
    wbeat = '{32'h11, 32'h22, 32'h33, 32'h44};
    wmask = '{4'h0, 4'h0, 4'h0, 4'h0};
    wr_burst("wr4", ROW_A | 21'h0FE, 3, 1'b0);
    rbeat = '{32'h11, 32'h22, 32'h33, 32'h44};
    rd_burst("rd4", ROW_A | 21'h0FE, 3, 1'b0, -1);
    check("rd4_hold", bus.O_sdrc_data, 32'h44);
    check("rd4_no_err", 32'(bus.o_proto_err), 32'd0);

    // Byte mask on a single-beat overwrite; read closes the row.
    wbeat[0] = 32'hAABBCCDD; wmask[0] = 4'b0000;
    wr_burst("wr_full", ROW_A | 21'h010, 0, 1'b0);
    wbeat[0] = 32'h11223344; wmask[0] = 4'b0101;
    wr_burst("wr_mask", ROW_A | 21'h010, 0, 1'b0);
    rbeat[0] = 32'h11BB33DD;
    rd_burst("rd_mask", ROW_A | 21'h010, 0, 1'b1, -1);
    check("mask_no_err", 32'(bus.o_proto_err), 32'd0);

    // Row now closed: a read must be refused.
    send(CMD_RD, ROW_A | 21'h0FE, 8'd0, 1'b0);
    saw_ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      saw_ack |= bus.O_sdrc_cmd_ack;
      step(1);
    end
    check("closed_rd_ack", 32'(saw_ack), 32'd0);
    check("closed_rd_err", 32'(bus.o_proto_err), 32'd1);
    check("closed_rd_data", bus.O_sdrc_data, 32'h11BB33DD);

    // Reset lands in the middle of a write burst.
    do_reset();
    send(CMD_ACT, ROW_A, 8'd0, 1'b0);
    step(3);
    wbeat = '{32'h5A5A0000, 32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003};
    wr_burst("wr_pre", ROW_A | 21'h040, 3, 1'b0);
    bus.I_sdrc_data = 32'hC0;
    bus.I_sdrc_dqm  = 4'h0;
    send(CMD_WR, ROW_A | 21'h040, 8'd3, 1'b0);
    bus.I_sdrc_data = 32'hC1;
    step(1);
    bus.I_sdrc_data = 32'hC2;
    reset_n = 1'b0;
    step(1);
    check_zero_outputs("midwr");

    // Only the beats before reset landed; a command mid-burst is flagged but harmless.
    do_reset();
    send(CMD_ACT, ROW_A, 8'd0, 1'b0);
    step(3);
    rbeat = '{32'hC0, 32'hC1, 32'h5A5A0002, 32'h5A5A0003};
    rd_burst("rd_abort", ROW_A | 21'h040, 3, 1'b0, 1);
    check("busy_cmd_err", 32'(bus.o_proto_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
